// File: rtl/mem_line_arbiter_if.sv
// Requester/core bus bundle for mem_line_arbiter.
// slave = arbiter view, master = requesters plus memory core.
interface mem_line_arbiter_if #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned LINE_WIDTH  = 128,
  parameter int unsigned LINE_ADDR_W = 8
);
  logic [NUM_REQ-1:0]             req_read;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ*LINE_ADDR_W-1:0] req_line_addr;
  logic [NUM_REQ*LINE_WIDTH-1:0]  req_line_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic                           rsp_hit;
  logic [LINE_WIDTH-1:0]          rsp_line_data;
  logic                           mem_read;
  logic                           mem_write;
  logic [LINE_ADDR_W-1:0]         mem_line_addr;
  logic [LINE_WIDTH-1:0]          mem_line_data;
  logic                           mem_rsp_valid;
  logic [LINE_WIDTH-1:0]          mem_rsp_line_data;

  modport slave (
    input  req_read, req_write, req_line_addr, req_line_data,
    input  mem_rsp_valid, mem_rsp_line_data,
    output req_ready, rsp_valid, rsp_hit, rsp_line_data,
    output mem_read, mem_write, mem_line_addr, mem_line_data
  );

  modport master (
    output req_read, req_write, req_line_addr, req_line_data,
    output mem_rsp_valid, mem_rsp_line_data,
    input  req_ready, rsp_valid, rsp_hit, rsp_line_data,
    input  mem_read, mem_write, mem_line_addr, mem_line_data
  );
endinterface

// File: rtl/mem_line_arbiter.sv
// Serialises line reads/writes from NUM_REQ requesters onto one memory core.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority (port 0 highest).
module mem_line_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned LINE_WIDTH  = 128,
  parameter int unsigned LINE_ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  mem_line_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       win_q, win_d;
  logic                   op_wr_q, op_wr_d;
  logic [LINE_ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0]  data_q, data_d;
  logic                   hit_q, hit_d;
  logic [LINE_WIDTH-1:0]  rdata_q, rdata_d;

  logic [NUM_REQ-1:0]     pend;
  logic                   found;
  logic [IDX_W-1:0]       pick;
  logic [NUM_REQ-1:0]     win_oh;
  logic [LINE_ADDR_W-1:0] req_addr [NUM_REQ];
  logic [LINE_WIDTH-1:0]  req_data [NUM_REQ];

  assign pend = bus.req_read | bus.req_write;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_addr[g] = bus.req_line_addr[g*LINE_ADDR_W +: LINE_ADDR_W];
    assign req_data[g] = bus.req_line_data[g*LINE_WIDTH +: LINE_WIDTH];
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  int unsigned      rr_idx;

  // ptr_q holds (last winner + 1) mod NUM_REQ, i.e. where the search begins
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    rr_idx = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rr_idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!found && pend[IDX_W'(rr_idx)]) begin
        found = 1'b1;
        pick  = IDX_W'(rr_idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && found) begin
      if ((32'(pick) + 32'd1) == NUM_REQ) ptr_d = '0;
      else                                ptr_d = pick + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && pend[IDX_W'(k)]) begin
        found = 1'b1;
        pick  = IDX_W'(k);
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    hit_d   = hit_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ISSUE;
          win_d   = pick;
          // read wins when both are set; the write stays pending for later
          op_wr_d = !bus.req_read[pick];
          addr_d  = req_addr[pick];
          data_d  = req_data[pick];
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d = RESP;
        if (op_wr_q) begin
          hit_d   = 1'b1;
          rdata_d = '0;
        end else begin
          hit_d   = bus.mem_rsp_valid;
          rdata_d = bus.mem_rsp_line_data;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      win_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      hit_q   <= hit_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    win_oh        = '0;
    win_oh[win_q] = 1'b1;
  end

  // Pulses are state decodes, masked so nothing strobes while reset is held
  assign bus.req_ready     = (!reset && state_q == ISSUE) ? win_oh : '0;
  assign bus.rsp_valid     = (!reset && state_q == RESP)  ? win_oh : '0;
  assign bus.mem_read      = !reset && state_q == ISSUE && !op_wr_q;
  assign bus.mem_write     = !reset && state_q == ISSUE &&  op_wr_q;
  assign bus.mem_line_addr = addr_q;
  assign bus.mem_line_data = data_q;
  assign bus.rsp_hit       = hit_q;
  assign bus.rsp_line_data = rdata_q;
endmodule

// File: tb/tb_mem_line_arbiter.sv
// Scoreboard bench for mem_line_arbiter: driver, memory-core model and monitor run
// as separate processes; the monitor predicts grants and responses transaction-by-transaction.
module tb_mem_line_arbiter;
  localparam int unsigned N  = 2;
  localparam int unsigned LW = 128;
  localparam int unsigned AW = 8;

  logic clock = 1'b0;
  logic reset;

  mem_line_arbiter_if #(.NUM_REQ(N), .LINE_WIDTH(LW), .LINE_ADDR_W(AW)) bus ();

  mem_line_arbiter #(.NUM_REQ(N), .LINE_WIDTH(LW), .LINE_ADDR_W(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clock = ~clock;

  // ---------------- memory core model ----------------
  logic [LW-1:0] core_mem [2**AW];
  logic          core_vld [2**AW];

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      core_mem[i] = '0;
      core_vld[i] = 1'b0;
    end
    bus.mem_rsp_valid     <= 1'b0;
    bus.mem_rsp_line_data <= '0;
    forever begin
      @(posedge clock);
      if (!reset) begin
        if (bus.mem_read) begin
          bus.mem_rsp_valid     <= core_vld[bus.mem_line_addr];
          bus.mem_rsp_line_data <= core_mem[bus.mem_line_addr];
        end else begin
          bus.mem_rsp_valid     <= 1'b0;
          bus.mem_rsp_line_data <= '1;
          if (bus.mem_write) begin
            core_mem[bus.mem_line_addr] = bus.mem_line_data;
            core_vld[bus.mem_line_addr] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  logic          d_rd   [N];
  logic          d_wr   [N];
  logic [AW-1:0] d_addr [N];
  logic [LW-1:0] d_data [N];
  int unsigned   grants = 0;
  int unsigned   tmo    = 0;
  logic          end_req = 1'b0;

  task automatic apply();
    for (int unsigned p = 0; p < N; p++) begin
      bus.req_read[p]               = d_rd[p];
      bus.req_write[p]              = d_wr[p];
      bus.req_line_addr[p*AW +: AW] = d_addr[p];
      bus.req_line_data[p*LW +: LW] = d_data[p];
    end
  endtask

  task automatic set_req(input int unsigned p, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [LW-1:0] d);
    d_rd[p] = r; d_wr[p] = w; d_addr[p] = a; d_data[p] = d;
    apply();
  endtask

  function automatic logic any_active();
    logic act = 1'b0;
    for (int unsigned p = 0; p < N; p++) act |= d_rd[p] | d_wr[p];
    return act;
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One cycle: sample accepts mid-cycle, retire them just after the next edge.
  task automatic step();
    logic [N-1:0] got;
    @(negedge clock);
    got = bus.req_ready;
    @(posedge clock);
    #1;
    for (int unsigned p = 0; p < N; p++) begin
      if (got[p]) begin
        grants++;
        if (d_rd[p] && d_wr[p]) d_rd[p] = 1'b0;
        else begin
          d_rd[p] = 1'b0;
          d_wr[p] = 1'b0;
        end
      end
    end
    apply();
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (any_active() && n < 300) begin
      step();
      n++;
    end
    if (any_active()) begin
      tmo++;
      for (int unsigned p = 0; p < N; p++) set_req(p, 1'b0, 1'b0, '0, '0);
    end
  endtask

  task automatic wait_grant();
    int unsigned g0 = grants;
    int unsigned n  = 0;
    while (grants == g0 && n < 30) begin
      step();
      n++;
    end
    if (grants == g0) tmo++;
  endtask

  initial begin
    int unsigned g0;
    int unsigned n;
    int unsigned r;
    reset = 1'b1;
    for (int unsigned p = 0; p < N; p++) begin
      d_rd[p] = 1'b0; d_wr[p] = 1'b0; d_addr[p] = '0; d_data[p] = '0;
    end
    apply();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // never-written line
    set_req(1, 1'b1, 1'b0, 8'h3C, '0);
    wait_idle();
    // write then read back
    set_req(0, 1'b0, 1'b1, 8'h05, {16{8'hA5}});
    wait_idle();
    set_req(0, 1'b1, 1'b0, 8'h05, '0);
    wait_idle();

    // both ports reading continuously for four grants
    for (int i = 0; i < 4; i++) begin
      for (int unsigned p = 0; p < N; p++)
        if (!d_rd[p]) set_req(p, 1'b1, 1'b0, AW'(8'h05 + p), rnd_line());
      wait_grant();
    end
    wait_idle();

    // read+write together on one port, then confirm the write landed
    set_req(0, 1'b1, 1'b1, 8'h10, {4{32'hC0DE_5A5A}});
    wait_idle();
    set_req(0, 1'b1, 1'b0, 8'h10, '0);
    wait_idle();

    // reset during WAIT drops the transaction
    set_req(0, 1'b1, 1'b0, 8'h05, '0);
    wait_grant();
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    set_req(1, 1'b1, 1'b0, 8'h05, '0);
    wait_idle();

    // random traffic
    g0 = grants;
    n  = 0;
    while (grants - g0 < 100 && n < 3000) begin
      for (int unsigned p = 0; p < N; p++) begin
        if (!d_rd[p] && !d_wr[p] && $urandom_range(1, 0) == 1) begin
          r = $urandom_range(99, 0);
          set_req(p, (r < 50 || r >= 85), (r >= 50), AW'($urandom_range(15, 0)), rnd_line());
        end
      end
      step();
      n++;
    end
    if (grants - g0 < 100) tmo++;
    wait_idle();

    repeat (6) @(posedge clock);
    end_req = 1'b1;
    repeat (20) @(posedge clock);
    $display("FAIL end_of_test: monitor did not close the run");
    $fatal(1);
  end

  // ---------------- reference model + monitor ----------------
  typedef struct {
    int unsigned   port;
    logic          hit;
    logic [LW-1:0] data;
    int unsigned   due;
  } exp_t;

  exp_t          q[$];
  logic [LW-1:0] ref_mem [int unsigned];
  int            total = 0;
  int            bad   = 0;
  int unsigned   cyc   = 0;

  task automatic check(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic int unsigned pick_winner(input logic [N-1:0] pend, input int unsigned last);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int unsigned k = 1; k <= N; k++)
      if (pend[(last + k) % N]) return (last + k) % N;
`else
    for (int unsigned k = 0; k < N; k++)
      if (pend[k]) return k;
`endif
    return 0;
  endfunction

  initial begin
    logic          rst_prev = 1'b0;
    logic          arb_fire = 1'b0;
    int unsigned   arb_w    = 0;
    logic          arb_wr   = 1'b0;
    logic [AW-1:0] arb_addr = '0;
    logic [LW-1:0] arb_data = '0;
    int unsigned   free_cyc = 0;
    int unsigned   last_w   = N - 1;
    logic          rstn;
    logic [N-1:0]  exp_rdy;
    logic [N-1:0]  exp_v;
    logic [N-1:0]  pend;
    exp_t          e;
    forever begin
      @(negedge clock);
      cyc++;
      rstn = reset;

      // accept pulse and core strobe predicted from last cycle's arbitration
      exp_rdy = '0;
      if (arb_fire && !rstn) exp_rdy[arb_w] = 1'b1;
      check("req_ready", bus.req_ready, exp_rdy);
      check("mem_read",  bus.mem_read,  arb_fire && !rstn && !arb_wr);
      check("mem_write", bus.mem_write, arb_fire && !rstn &&  arb_wr);
      if (arb_fire && !rstn) begin
        check("mem_line_addr", bus.mem_line_addr, arb_addr);
        check("mem_line_data", bus.mem_line_data, arb_data);
        e.port = arb_w;
        e.due  = cyc + 2;
        if (arb_wr) begin
          ref_mem[arb_addr] = arb_data;
          e.hit  = 1'b1;
          e.data = '0;
        end else begin
          e.hit  = ref_mem.exists(arb_addr);
          e.data = e.hit ? ref_mem[arb_addr] : '0;
        end
        q.push_back(e);
      end

      if (rst_prev) begin
        check("reset_rsp_hit",       bus.rsp_hit,       '0);
        check("reset_rsp_line_data", bus.rsp_line_data, '0);
        check("reset_mem_line_addr", bus.mem_line_addr, '0);
        check("reset_mem_line_data", bus.mem_line_data, '0);
      end

      if (rstn) begin
        q.delete();
        check("rsp_valid_in_reset", bus.rsp_valid, '0);
      end else if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front();
        exp_v = '0;
        exp_v[e.port] = 1'b1;
        check("rsp_valid",     bus.rsp_valid,     exp_v);
        check("rsp_hit",       bus.rsp_hit,       e.hit);
        check("rsp_line_data", bus.rsp_line_data, e.data);
      end else begin
        check("rsp_valid_idle", bus.rsp_valid, '0);
      end

      // arbitration decision taken in this cycle, visible next cycle
      pend = bus.req_read | bus.req_write;
      if (rstn) begin
        arb_fire = 1'b0;
        free_cyc = cyc + 1;
        last_w   = N - 1;
      end else begin
        arb_fire = (cyc >= free_cyc) && (pend != '0);
        if (arb_fire) begin
          arb_w    = pick_winner(pend, last_w);
          arb_wr   = !bus.req_read[arb_w];
          arb_addr = bus.req_line_addr[arb_w*AW +: AW];
          arb_data = bus.req_line_data[arb_w*LW +: LW];
          last_w   = arb_w;
          free_cyc = cyc + 4;
        end
      end
      rst_prev = rstn;

      if (end_req) begin
        check("scoreboard_drained", LW'(q.size()), '0);
        check("driver_timeouts",    LW'(tmo),      '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end
endmodule

// File: doc/mem_line_arbiter.md
# mem_line_arbiter

Shares the single line-granular memory core between `NUM_REQ` requesters (port 0 = instruction-fetch side, port 1 = data side by default). It accepts one line read or line write at a time and drives the core's `read`/`write`/`line_addr`/`line_data` request for exactly one cycle. It captures the core's registered `valid`/`line_data` response and returns it to the granted requester as a one-cycle response pulse. It sits between the fetch/LSU miss paths and the memory core.

## Interface
- `NUM_REQ`, default 2: number of requesters (2..4).
- `LINE_WIDTH`, default 128: line width in bits.
- `LINE_ADDR_W`, default 8: line-index width; must cover `MEM_SIZE/(LINE_WIDTH/8)`.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_read`  in  NUM_REQ  per-requester read request; held until accepted.
- `req_write`  in  NUM_REQ  per-requester write request; held until accepted.
- `req_line_addr`  in  NUM_REQ*LINE_ADDR_W  packed line index, requester i at slice i.
- `req_line_data`  in  NUM_REQ*LINE_WIDTH  packed write data.
- `req_ready`  out  NUM_REQ  one-hot accept pulse.
- `rsp_valid`  out  NUM_REQ  one-hot response pulse.
- `rsp_hit`  out  1  reads: line-valid bit from the core; writes: 1.
- `rsp_line_data`  out  LINE_WIDTH  read data; 0 for writes.
- `mem_read`, `mem_write`  out  1  core request strobes.
- `mem_line_addr`  out  LINE_ADDR_W  core line index.
- `mem_line_data`  out  LINE_WIDTH  core write data.
- `mem_rsp_valid`  in  1  core response valid bit (registered by the core).
- `mem_rsp_line_data`  in  LINE_WIDTH  core response data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - A requester is pending if its `req_read | req_write` is set.
  - With any requester pending, pick a winner and latch its index, op, addr and data into registers, then go to ISSUE.
  - With no requester pending, stay in IDLE.
- ISSUE:
  - Drive `mem_read` or `mem_write` from the latched op; drive `mem_line_addr`/`mem_line_data` from the latched values.
  - Pulse `req_ready[winner]`. Go to WAIT.
- WAIT:
  - The core's response is valid this cycle.
  - Latch `rsp_hit`/`rsp_line_data`: reads take the core values; writes take hit=1, data=0. Go to RESP.
- RESP: `rsp_valid[winner]`=1 for one cycle. Go to IDLE.
- Read and write both asserted by one requester: treated as a read (the core also gives read priority). The write stays pending and is served in a later transaction.
- Requesters must hold op/addr/data stable from assertion until `req_ready`. Changes before acceptance are a protocol violation; the latched values win.
- `mem_*` strobes are 0 in every state except ISSUE. `mem_line_addr`/`mem_line_data` hold their last latched values.
- Reset in any state:
  - Next state is IDLE.
  - All `req_ready`, `rsp_valid`, `mem_read`, `mem_write` are 0; `rsp_hit` is 0; `rsp_line_data`, `mem_line_addr`, `mem_line_data` are 0.
  - An in-flight transaction is dropped with no response. The core ignores requests under reset.

## Timing
- Request seen in IDLE at cycle T → ISSUE/`req_ready` at T+1 → core strobe at T+1 → WAIT at T+2 → `rsp_valid` at T+3.
- Throughput: one transaction per 4 cycles. Back-to-back: next arbitration in IDLE at T+4, first strobe of the next transaction at T+5.
- All outputs are registered or decoded only from the state register. There is no combinational path from `req_*` to `mem_*` or `req_ready`.
- A requester may re-assert in its RESP cycle. The new request is considered at the following IDLE.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration, with a pointer register reset to 0.
  - Search starts at (last_winner+1) mod NUM_REQ.
  - The pointer updates when leaving IDLE.
- `MEM_ARB_ROUND_ROBIN_EN` undefined: fixed priority, lowest index wins. Port 1 can starve while port 0 stays continuously pending.

## Test plan
- Write then read: port 0 writes addr 0x05 data 0xA5…A5 → `rsp_valid[0]` at T+3 with hit=1. Port 0 then reads 0x05 → hit=1, data 0xA5…A5.
- Read of a never-written line: port 1 reads 0x3C after reset → `rsp_valid[1]`, `rsp_hit`=0.
- Simultaneous requests, read on both ports:
  - With `MEM_ARB_ROUND_ROBIN_EN`: grants alternate 0,1,0,1 over 4 transactions, 4 cycles apart.
  - Without it: port 0 is granted every time while it stays asserted.
- Same-requester read+write on port 0, addr 0x10 → read served first (`mem_read`=1, `mem_write`=0). The write is issued in the next transaction.
- Reset asserted in the WAIT cycle → no `rsp_valid` pulse, all strobes 0 the next cycle, FSM in IDLE. A fresh read then completes in 3 cycles.
- Strobe check: over 100 random transactions, `mem_read|mem_write` is high exactly one cycle per `req_ready` pulse and is never high together with `reset`.
